// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified I/D memory arbiter.
//   mem_arb_state_t : arbiter FSM states (IDLE, WAIT_I, WAIT_D)
//   mem_arb_owner_t : owner of a granted transaction (OWN_I, OWN_D)
//   BE_FULL         : byte-enable pattern presented on every read
//   STREAK_W        : width of the starvation streak counter
//   selectOwner     : priority decision between the two requesters
//------------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_arb_owner_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  localparam int unsigned STREAK_W = 4;

  // D wins unless both ports request and the starvation guard is tripped.
  // Only meaningful when at least one request is present.
  function automatic mem_arb_owner_t selectOwner(input logic iReq,
                                                 input logic dReq,
                                                 input logic guardHit);
    mem_arb_owner_t owner;
    owner = OWN_I;
    if (dReq && !(iReq && guardHit)) begin
      owner = OWN_D;
    end
    return owner;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/arb_starve_ctr.sv
//------------------------------------------------------------------------------
// arb_starve_ctr
// Saturating streak counter for the arbiter's starvation guard. Counts D
// grants issued while the fetch port was also waiting; any I grant clears it.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the streak
//   incEn  : a D grant was issued this cycle while i_req was high
//   clrEn  : an I grant was issued this cycle (wins over incEn)
//   streak : current streak, saturates at LIMIT
//------------------------------------------------------------------------------
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                incEn,
  input  logic                clrEn,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] LIMIT_VAL = STREAK_W'(LIMIT);

  // Streak register: clear on I grant, count D-over-I grants up to LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (clrEn) begin
      streak <= '0;
    end else if (incEn && (streak != LIMIT_VAL)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

endmodule : arb_starve_ctr

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port unified memory between the fetch (I) and memory-stage
// (D) ports. One transaction is outstanding at a time; the response is routed
// only to the port that owns it. D has priority over I.
//
// Build option:
//   MEM_ARB_STARVE_GUARD_EN : when defined, after STARVE_LIMIT consecutive D
//                             grants with I waiting, the next contested IDLE
//                             cycle is given to I. Undefined: D always wins.
//
// Parameters:
//   DATA_WIDTH   : address and data width
//   STARVE_LIMIT : D-grant streak that forces an I grant (1..15)
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_req, i_addr              : fetch read request (held until i_gnt)
//   i_gnt, i_rvalid, i_rdata   : fetch accept / response
//   d_req, d_we, d_be,
//   d_addr, d_wdata            : data request (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata   : data accept / response (store ack on rvalid)
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata        : request to the memory macro
//   mem_rvalid, mem_rdata      : one completion pulse per accepted request
//
// Grants and response strobes are combinational: a request seen in IDLE is
// granted in the same cycle and a completion is forwarded in the cycle it
// arrives. All of them are forced low while reset is asserted.
//------------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch port
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  mem_arb_state_t state;
  mem_arb_state_t nextState;
  mem_arb_owner_t winner;
  logic           guardHit;

  //----------------------------------------------------------------------------
  // Starvation guard
  //----------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STREAK_W-1:0] streak;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) uStarveCtr (
    .clk    (clk),
    .reset  (reset),
    .incEn  (d_gnt & i_req),
    .clrEn  (i_gnt),
    .streak (streak)
  );

  assign guardHit = (streak == STREAK_W'(STARVE_LIMIT));
`else
  // No counter in this build; the legal range 1..15 makes this constant 0.
  assign guardHit = (STARVE_LIMIT == 0);
`endif

  assign winner = selectOwner(i_req, d_req, guardHit);

  // Read data is a straight pass-through, qualified only by the rvalid strobes.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  //----------------------------------------------------------------------------
  // State register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  //----------------------------------------------------------------------------
  // Next state, grants, memory request mux and response routing
  //----------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          // A stray mem_rvalid here is ignored on purpose.
          if (i_req || d_req) begin
            mem_req = 1'b1;
            if (winner == OWN_D) begin
              d_gnt     = 1'b1;
              mem_we    = d_we;
              mem_be    = d_we ? d_be : BE_FULL;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
              nextState = WAIT_D;
            end else begin
              i_gnt     = 1'b1;
              mem_be    = BE_FULL;
              mem_addr  = i_addr;
              nextState = WAIT_I;
            end
          end
        end

        // No new grant in a completion cycle; the next one starts from IDLE.
        WAIT_I: begin
          if (mem_rvalid) begin
            i_rvalid  = 1'b1;
            nextState = IDLE;
          end
        end

        WAIT_D: begin
          if (mem_rvalid) begin
            d_rvalid  = 1'b1;
            nextState = IDLE;
          end
        end

        default: nextState = IDLE;
      endcase
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge and outputs are sampled 1 ns later, so each check sees the
// combinational response to the current state and inputs.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [DW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int tests;
  int fails;

  mem_arbiter #(
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    #1;
    tests++; if (i_gnt !== 1'b0) begin fails++; $display("FAIL reset_i_gnt: got %b required 0", i_gnt); end
    tests++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt: got %b required 0", d_gnt); end
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got i=%b d=%b required 0 0", i_rvalid, d_rvalid); end
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_req_we: got req=%b we=%b required 0 0", mem_req, mem_we); end
    tests++; if (mem_be !== 4'h0) begin fails++; $display("FAIL reset_mem_be: got %h required 0", mem_be); end
    tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_addr_wdata: got %h %h required 0 0", mem_addr, mem_wdata); end
    @(negedge clk);
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL idle_no_req: got mem_req=%b required 0", mem_req); end
  endtask

  task automatic test_single_i_read();
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    #1;
    tests++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin fails++; $display("FAIL iread_gnt: got i=%b d=%b required 1 0", i_gnt, d_gnt); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL iread_mem: got req=%b addr=%h required 1 00000010", mem_req, mem_addr); end
    tests++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin fails++; $display("FAIL iread_we_be: got we=%b be=%h required 0 f", mem_we, mem_be); end
    @(negedge clk);
    i_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL iread_resp: got v=%b data=%h required 1 deadbeef", i_rvalid, i_rdata); end
    tests++; if (d_rvalid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL iread_cross: got d_rvalid=%b mem_req=%b required 0 0", d_rvalid, mem_req); end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0200;
    #1;
    tests++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin fails++; $display("FAIL simul_c0_gnt: got d=%b i=%b required 1 0", d_gnt, i_gnt); end
    tests++; if (mem_addr !== 32'h200 || mem_be !== 4'hF || mem_we !== 1'b0) begin fails++; $display("FAIL simul_c0_mem: got addr=%h be=%h we=%b required 00000200 f 0", mem_addr, mem_be, mem_we); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || i_gnt !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL simul_c1_wait: got req=%b ig=%b dv=%b required 0 0 0", mem_req, i_gnt, d_rvalid); end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0001;
    #1;
    tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin fails++; $display("FAIL simul_c2_resp: got v=%b data=%h required 1 cafe0001", d_rvalid, d_rdata); end
    tests++; if (i_rvalid !== 1'b0 || i_gnt !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL simul_c2_nognt: got iv=%b ig=%b req=%b required 0 0 0", i_rvalid, i_gnt, mem_req); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    tests++; if (i_gnt !== 1'b1 || mem_addr !== 32'h40) begin fails++; $display("FAIL simul_c3_igrant: got ig=%b addr=%h required 1 00000040", i_gnt, mem_addr); end
    @(negedge clk);
    i_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    #1;
    tests++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL simul_c4_iresp: got v=%b data=%h required 1 0badf00d", i_rvalid, i_rdata); end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h1234_ABCD;
    #1;
    tests++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL store_gnt_we: got gnt=%b we=%b required 1 1", d_gnt, mem_we); end
    tests++; if (mem_be !== 4'b0011 || mem_wdata !== 32'h1234_ABCD || mem_addr !== 32'h300) begin fails++; $display("FAIL store_fields: got be=%h wdata=%h addr=%h required 3 1234abcd 00000300", mem_be, mem_wdata, mem_addr); end
    @(negedge clk);
    d_req      = 1'b0;
    d_we       = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0;
    #1;
    tests++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin fails++; $display("FAIL store_ack: got dv=%b iv=%b required 1 0", d_rvalid, i_rvalid); end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_starve_guard();
    logic expD;
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h0000_0080;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0400;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      expD = ((k % (LIMIT + 1)) != LIMIT);
`else
      expD = 1'b1;
`endif
      #1;
      tests++; if (d_gnt !== expD || i_gnt !== !expD) begin fails++; $display("FAIL guard_gnt_%0d: got d=%b i=%b required %b %b", k, d_gnt, i_gnt, expD, !expD); end
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7700_0000 + 32'(k);
      #1;
      tests++; if (d_rvalid !== expD || i_rvalid !== !expD) begin fails++; $display("FAIL guard_resp_%0d: got dv=%b iv=%b required %b %b", k, d_rvalid, i_rvalid, expD, !expD); end
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL guard_drain: got mem_req=%b required 0", mem_req); end
  endtask

  task automatic test_reset_mid_txn();
    @(negedge clk);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    #1;
    tests++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL rmid_gnt: got %b required 1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_0000;
    #1;
    tests++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_drop: got dv=%b iv=%b required 0 0", d_rvalid, i_rvalid); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_idle_req: got %b required 0", mem_req); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    i_req      = 1'b1;
    i_addr     = 32'h0000_0600;
    #1;
    tests++; if (i_gnt !== 1'b1 || mem_addr !== 32'h600) begin fails++; $display("FAIL rmid_idle_gnt: got ig=%b addr=%h required 1 00000600", i_gnt, mem_addr); end
    @(negedge clk);
    i_req      = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    tests++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_after: got iv=%b dv=%b required 1 0", i_rvalid, d_rvalid); end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic test_stray_rvalid();
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    #1;
    tests++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL stray_rvalid: got iv=%b dv=%b required 0 0", i_rvalid, d_rvalid); end
    tests++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL stray_gnt: got ig=%b dg=%b req=%b required 0 0 0", i_gnt, d_gnt, mem_req); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    d_req      = 1'b1;
    d_addr     = 32'h0000_0700;
    #1;
    tests++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL stray_then_gnt: got %b required 1", d_gnt); end
    @(negedge clk);
    d_req      = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    tests++; if (d_rvalid !== 1'b1) begin fails++; $display("FAIL stray_then_resp: got %b required 1", d_rvalid); end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_be       = 4'h0;
    d_addr     = '0;
    d_wdata    = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    test_reset();
    test_single_i_read();
    test_simultaneous();
    test_store();
    test_starve_guard();
    test_reset_mid_txn();
    test_stray_rvalid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_arbiter
